// File: rtl/neural_cmd_sequencer_if.sv
// neural_cmd_sequencer_if: host command push port and result pop port, both valid/ready.
interface neural_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_type;
    logic [15:0] cmd_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    modport master (output cmd_valid, cmd_type, cmd_data, res_ready, input cmd_ready, res_valid, res_data);
    modport slave  (input cmd_valid, cmd_type, cmd_data, res_ready, output cmd_ready, res_valid, res_data);
endinterface

// File: rtl/neural_cmd_sequencer.sv
// neural_cmd_sequencer: buffers host commands and turns them into accelerator load/compute strobes.
// Optional WAIT watchdog enabled by defining NEURAL_CMD_SEQ_TIMEOUT_EN.
module neural_cmd_sequencer #(
    parameter int FIFO_DEPTH   = 8,
    parameter int WEIGHT_COUNT = 128
`ifdef NEURAL_CMD_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    neural_cmd_sequencer_if.slave           bus,
    output logic                            o_weight_load,
    output logic [15:0]                     o_weight_data,
    output logic                            o_compute_start,
    output logic [15:0]                     o_input_data,
    input  logic [15:0]                     i_output_data,
    input  logic                            i_compute_done,
    output logic                            o_busy,
    output logic [$clog2(WEIGHT_COUNT)-1:0] o_weight_cnt,
    output logic                            o_weights_full,
    output logic                            o_timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WEIGHT_COUNT);
    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
    state_t          r_state, w_next;
    logic [16:0]     r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr, r_rd_ptr;
    logic            w_full, w_empty, w_push, w_pop, w_expire;
    logic [16:0]     w_head;
    logic            r_res_valid, r_weight_load, r_compute_start, r_weights_full;
    logic [15:0]     r_res_data, r_weight_data, r_input_data;
    logic [CW-1:0]   r_weight_cnt;

    assign w_empty         = r_wr_ptr == r_rd_ptr;
    assign w_full          = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push          = bus.cmd_valid && !w_full;
    assign w_head          = r_mem[r_rd_ptr[AW-1:0]];
    assign bus.cmd_ready   = !w_full;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign o_weight_load   = r_weight_load;
    assign o_weight_data   = r_weight_data;
    assign o_compute_start = r_compute_start;
    assign o_input_data    = r_input_data;
    assign o_weight_cnt    = r_weight_cnt;
    assign o_weights_full  = r_weights_full;
    assign o_busy          = (r_state != IDLE) || !w_empty;

`ifdef NEURAL_CMD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_timeout_err;
    // counter is zero on the first WAIT cycle, so expiry lands on the TIMEOUT_CYCLES-th one
    assign w_expire      = (r_state == WAIT) && !i_compute_done && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign o_timeout_err = r_timeout_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tcnt <= (r_state == WAIT) ? r_tcnt + 1'b1 : '0;
            if (w_expire) r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_expire      = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {bus.cmd_type, bus.cmd_data};
    end

    // samples stall at the head while an unconsumed result is held
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: if (!w_empty && (!w_head[16] || !r_res_valid)) begin
                w_pop  = 1'b1;
                w_next = w_head[16] ? START : LOAD;
            end
            LOAD:    w_next = IDLE;
            START:   w_next = WAIT;
            WAIT:    w_next = (i_compute_done || w_expire) ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_weight_load   <= 1'b0;
            r_compute_start <= 1'b0;
            r_weight_data   <= '0;
            r_input_data    <= '0;
            r_weight_cnt    <= '0;
            r_weights_full  <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_data      <= '0;
        end else begin
            r_state         <= w_next;
            r_weight_load   <= w_pop && !w_head[16];
            r_compute_start <= w_pop && w_head[16];
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_pop && !w_head[16]) r_weight_data <= w_head[15:0];
            if (w_pop && w_head[16]) r_input_data <= w_head[15:0];
            if (r_state == LOAD) begin
                r_weight_cnt <= (r_weight_cnt == CW'(WEIGHT_COUNT - 1)) ? '0 : r_weight_cnt + 1'b1;
                if (r_weight_cnt == CW'(WEIGHT_COUNT - 1)) r_weights_full <= 1'b1;
            end
            if ((r_state == WAIT) && i_compute_done) begin
                r_res_data  <= i_output_data;
                r_res_valid <= 1'b1;
            end else if (w_expire) begin
                r_res_data  <= 16'hDEAD;
                r_res_valid <= 1'b1;
            end else if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_neural_cmd_sequencer.sv
// tb_neural_cmd_sequencer: scenario tasks plus a randomized run scored against a queue-based model.
module tb_neural_cmd_sequencer;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    neural_cmd_sequencer_if ifc();
    logic        weight_load, compute_start, compute_done, busy, weights_full, timeout_err;
    logic [15:0] weight_data, input_data, output_data;
    logic [6:0]  weight_cnt;

    neural_cmd_sequencer dut (
        .clk(clk), .rst(rst), .bus(ifc),
        .o_weight_load(weight_load), .o_weight_data(weight_data),
        .o_compute_start(compute_start), .o_input_data(input_data),
        .i_output_data(output_data), .i_compute_done(compute_done),
        .o_busy(busy), .o_weight_cnt(weight_cnt), .o_weights_full(weights_full),
        .o_timeout_err(timeout_err)
    );

    int checks = 0, errors = 0, cyc = 0, tw = 0;
    int both_cnt = 0, unstable = 0;
    int wl_cyc[$], cs_cyc[$];
    logic [15:0] wl_dat[$], cs_dat[$];
    logic wl_wf[$];
    logic prev_rv = 1'b0;
    logic [15:0] prev_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // records every accelerator strobe and watches result-port stability
    always @(negedge clk) begin
        if (weight_load) begin
            wl_cyc.push_back(cyc);
            wl_dat.push_back(weight_data);
            wl_wf.push_back(weights_full);
        end
        if (compute_start) begin
            cs_cyc.push_back(cyc);
            cs_dat.push_back(input_data);
        end
        if (weight_load && compute_start) both_cnt++;
        if (prev_rv && ifc.res_valid && ifc.res_data !== prev_rd) unstable++;
        prev_rv = ifc.res_valid;
        prev_rd = ifc.res_data;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q;
        wl_cyc.delete(); wl_dat.delete(); wl_wf.delete();
        cs_cyc.delete(); cs_dat.delete();
        both_cnt = 0; unstable = 0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ifc.cmd_valid = 1'b0; ifc.cmd_type = 1'b0; ifc.cmd_data = '0; ifc.res_ready = 1'b0;
        compute_done = 1'b0; output_data = '0;
        step(2);
        rst = 1'b0;
        tw = 0;
        clear_q();
    endtask

    task automatic push(input logic t, input logic [15:0] d, output int a);
        int n = 0;
        ifc.cmd_valid = 1'b1; ifc.cmd_type = t; ifc.cmd_data = d;
        while (!ifc.cmd_ready && n < 500) begin
            step(1);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL push_wait: cmd_ready stuck at 0 for %0d cycles, required 1", n);
        end
        step(1);
        a = cyc;
        ifc.cmd_valid = 1'b0;
        if (!t) tw++;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!compute_start && n < 40) begin
            step(1);
            n++;
        end
        checks++;
        if (compute_start !== 1'b1) begin
            errors++;
            $display("FAIL %s: compute_start=%b after %0d cycles, required 1", nm, compute_start, n);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 2000) begin
            step(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s: busy=%b, required 0", nm, busy); end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({weight_load, compute_start, ifc.res_valid, busy, weights_full, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: wl/cs/rv/busy/wf/to=%b, required 000000",
                     {weight_load, compute_start, ifc.res_valid, busy, weights_full, timeout_err});
        end
        checks++;
        if (weight_cnt !== 7'd0) begin errors++; $display("FAIL reset_cnt: weight_cnt=%0d, required 0", weight_cnt); end
        checks++;
        if ({weight_data, input_data, ifc.res_data} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: wd=%h id=%h rd=%h, required 0", weight_data, input_data, ifc.res_data);
        end
        checks++;
        if (ifc.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: cmd_ready=%b, required 1", ifc.cmd_ready); end
    endtask

    task automatic test_single_weight;
        int a;
        push(1'b0, 16'h1234, a);
        checks++;
        if (weight_load !== 1'b0) begin errors++; $display("FAIL wl_t1: weight_load=%b, required 0", weight_load); end
        step(1);
        checks++;
        if (weight_load !== 1'b1 || weight_data !== 16'h1234) begin
            errors++;
            $display("FAIL wl_t2: weight_load=%b weight_data=%h, required 1/1234", weight_load, weight_data);
        end
        step(1);
        checks++;
        if (weight_load !== 1'b0) begin errors++; $display("FAIL wl_t3: weight_load=%b, required 0", weight_load); end
        checks++;
        if (weight_cnt !== 7'd1) begin errors++; $display("FAIL wl_cnt: weight_cnt=%0d, required 1", weight_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp[$];
        logic [15:0] d;
        int a;
        clear_q();
        for (int i = 0; i < 127; i++) begin
            d = 16'($urandom);
            exp.push_back(d);
            push(1'b0, d, a);
        end
        wait_idle("b2b_drain");
        checks++;
        if (wl_dat.size() !== 127) begin errors++; $display("FAIL b2b_count: pulses=%0d, required 127", wl_dat.size()); end
        for (int i = 0; i < exp.size() && i < wl_dat.size(); i++) begin
            checks++;
            if (wl_dat[i] !== exp[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, wl_dat[i], exp[i]); end
            checks++;
            if (wl_wf[i] !== 1'b0) begin errors++; $display("FAIL b2b_wf_early[%0d]: weights_full=%b, required 0", i, wl_wf[i]); end
            if (i > 0) begin
                checks++;
                if (wl_cyc[i] - wl_cyc[i-1] !== 2) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d]: gap=%0d, required 2", i, wl_cyc[i] - wl_cyc[i-1]);
                end
            end
        end
        checks++;
        if (weight_cnt !== 7'(tw % 128) || weight_cnt !== 7'd0) begin
            errors++;
            $display("FAIL b2b_wrap: weight_cnt=%0d, required 0", weight_cnt);
        end
        checks++;
        if (weights_full !== 1'b1) begin errors++; $display("FAIL b2b_full: weights_full=%b, required 1", weights_full); end
    endtask

    task automatic test_compute;
        int a, c;
        push(1'b1, 16'h00A5, a);
        wait_start("cmp_start");
        c = cyc;
        checks++;
        if (c !== a + 1 || input_data !== 16'h00A5) begin
            errors++;
            $display("FAIL cmp_lat: cycle=%0d data=%h, required %0d/00a5", c, input_data, a + 1);
        end
        step(50);
        checks++;
        if (busy !== 1'b1 || ifc.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL cmp_wait: busy=%b res_valid=%b, required 1/0", busy, ifc.res_valid);
        end
        compute_done = 1'b1; output_data = 16'hBEEF;
        step(1);
        compute_done = 1'b0; output_data = 16'($urandom);
        checks++;
        if (ifc.res_valid !== 1'b1 || ifc.res_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL cmp_res: res_valid=%b res_data=%h, required 1/beef", ifc.res_valid, ifc.res_data);
        end
        checks++;
        if (busy !== 1'b0 || input_data !== 16'h00A5) begin
            errors++;
            $display("FAIL cmp_idle: busy=%b input_data=%h, required 0/00a5", busy, input_data);
        end
    endtask

    task automatic test_stall;
        logic [15:0] s2, r, d;
        logic [15:0] w[$];
        int a;
        clear_q();
        s2 = 16'($urandom);
        push(1'b1, s2, a);
        for (int i = 0; i < 7; i++) begin
            d = 16'($urandom);
            w.push_back(d);
            push(1'b0, d, a);
        end
        checks++;
        if (ifc.cmd_ready !== 1'b0) begin errors++; $display("FAIL stall_full: cmd_ready=%b, required 0", ifc.cmd_ready); end
        step(10);
        checks++;
        if (cs_dat.size() !== 0 || ifc.res_valid !== 1'b1 || ifc.res_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL stall_hold: starts=%0d res_valid=%b res_data=%h, required 0/1/beef",
                     cs_dat.size(), ifc.res_valid, ifc.res_data);
        end
        checks++;
        if (ifc.cmd_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: cmd_ready=%b, required 0", ifc.cmd_ready); end
        ifc.res_ready = 1'b1;
        step(1);
        ifc.res_ready = 1'b0;
        checks++;
        if (ifc.res_valid !== 1'b0) begin errors++; $display("FAIL stall_consume: res_valid=%b, required 0", ifc.res_valid); end
        wait_start("stall_start");
        checks++;
        if (input_data !== s2) begin errors++; $display("FAIL stall_data: input_data=%h, required %h", input_data, s2); end
        r = 16'($urandom);
        step(3);
        compute_done = 1'b1; output_data = r;
        step(1);
        compute_done = 1'b0;
        checks++;
        if (ifc.res_valid !== 1'b1 || ifc.res_data !== r) begin
            errors++;
            $display("FAIL stall_res: res_valid=%b res_data=%h, required 1/%h", ifc.res_valid, ifc.res_data, r);
        end
        wait_idle("stall_drain");
        checks++;
        if (wl_dat.size() !== 7) begin errors++; $display("FAIL stall_wcount: pulses=%0d, required 7", wl_dat.size()); end
        for (int i = 0; i < w.size() && i < wl_dat.size(); i++) begin
            checks++;
            if (wl_dat[i] !== w[i]) begin errors++; $display("FAIL stall_w[%0d]: got %h, required %h", i, wl_dat[i], w[i]); end
        end
        checks++;
        if (weight_cnt !== 7'(tw % 128) || weights_full !== (tw >= 128)) begin
            errors++;
            $display("FAIL stall_cnt: weight_cnt=%0d weights_full=%b, required %0d/%b", weight_cnt, weights_full, tw % 128, tw >= 128);
        end
        ifc.res_ready = 1'b1;
        step(1);
        ifc.res_ready = 1'b0;
    endtask

    task automatic test_reset_wait;
        int a;
        push(1'b1, 16'($urandom), a);
        wait_start("rw_start");
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        tw = 0;
        compute_done = 1'b1; output_data = 16'($urandom);
        step(1);
        compute_done = 1'b0;
        step(2);
        checks++;
        if (ifc.res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rw_state: res_valid=%b busy=%b, required 0/0", ifc.res_valid, busy);
        end
        checks++;
        if (ifc.cmd_ready !== 1'b1 || weight_cnt !== 7'd0 || weights_full !== 1'b0) begin
            errors++;
            $display("FAIL rw_clear: cmd_ready=%b weight_cnt=%0d weights_full=%b, required 1/0/0",
                     ifc.cmd_ready, weight_cnt, weights_full);
        end
    endtask

    task automatic test_random;
        logic [15:0] exp_w[$], exp_s[$], exp_r[$], got_r[$];
        logic [15:0] resp = '0;
        int pend = -1, n = 0, issued = 0;
        bit drain = 1'b0, acc, rr;
        clear_q();
        ifc.cmd_valid = 1'b0;
        while (n < 4000) begin
            acc = ifc.cmd_valid && ifc.cmd_ready;
            rr  = ifc.res_valid && ifc.res_ready;
            if (acc) begin
                issued++;
                if (ifc.cmd_type) exp_s.push_back(ifc.cmd_data);
                else begin exp_w.push_back(ifc.cmd_data); tw++; end
            end
            if (rr) got_r.push_back(ifc.res_data);
            step(1);
            n++;
            drain = issued >= 150;
            if (drain) ifc.cmd_valid = 1'b0;
            else if (acc || !ifc.cmd_valid) begin
                ifc.cmd_valid = $urandom_range(0, 3) != 0;
                ifc.cmd_type  = $urandom_range(0, 2) == 0;
                ifc.cmd_data  = 16'($urandom);
            end
            ifc.res_ready = drain || ($urandom_range(0, 2) == 0);
            compute_done = 1'b0;
            if (compute_start) begin
                pend = $urandom_range(1, 6);
                resp = 16'($urandom);
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    compute_done = 1'b1; output_data = resp;
                    exp_r.push_back(resp);
                    pend = -1;
                end
            end
            if (drain && !busy && !ifc.res_valid && pend < 0 && !compute_done) break;
        end
        ifc.res_ready = 1'b0;
        checks++;
        if (n >= 4000) begin errors++; $display("FAIL rnd_drain: run did not drain in %0d cycles, required fewer", n); end
        checks++;
        if (wl_dat.size() !== exp_w.size() || cs_dat.size() !== exp_s.size() || got_r.size() !== exp_r.size()) begin
            errors++;
            $display("FAIL rnd_counts: w=%0d s=%0d r=%0d, required %0d/%0d/%0d",
                     wl_dat.size(), cs_dat.size(), got_r.size(), exp_w.size(), exp_s.size(), exp_r.size());
        end
        for (int i = 0; i < exp_w.size() && i < wl_dat.size(); i++) begin
            checks++;
            if (wl_dat[i] !== exp_w[i]) begin errors++; $display("FAIL rnd_w[%0d]: got %h, required %h", i, wl_dat[i], exp_w[i]); end
            if (i > 0) begin
                checks++;
                if (wl_cyc[i] - wl_cyc[i-1] < 2) begin errors++; $display("FAIL rnd_wgap[%0d]: gap=%0d, required >=2", i, wl_cyc[i] - wl_cyc[i-1]); end
            end
        end
        for (int i = 0; i < exp_s.size() && i < cs_dat.size(); i++) begin
            checks++;
            if (cs_dat[i] !== exp_s[i]) begin errors++; $display("FAIL rnd_s[%0d]: got %h, required %h", i, cs_dat[i], exp_s[i]); end
        end
        for (int i = 0; i < exp_r.size() && i < got_r.size(); i++) begin
            checks++;
            if (got_r[i] !== exp_r[i]) begin errors++; $display("FAIL rnd_r[%0d]: got %h, required %h", i, got_r[i], exp_r[i]); end
        end
        checks++;
        if (both_cnt !== 0 || unstable !== 0) begin
            errors++;
            $display("FAIL rnd_rules: overlap=%0d res_changes=%0d, required 0/0", both_cnt, unstable);
        end
        checks++;
        if (weight_cnt !== 7'(tw % 128) || weights_full !== (tw >= 128) || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL rnd_cnt: weight_cnt=%0d weights_full=%b timeout_err=%b, required %0d/%b/0",
                     weight_cnt, weights_full, timeout_err, tw % 128, tw >= 128);
        end
    endtask

`ifdef NEURAL_CMD_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int a, n = 0;
        do_reset();
        push(1'b1, 16'($urandom), a);
        wait_start("to_start");
        while (!ifc.res_valid && n < 1100) begin
            step(1);
            n++;
        end
        checks++;
        if (n !== 1025) begin errors++; $display("FAIL to_lat: res_valid after %0d cycles, required 1025", n); end
        checks++;
        if (timeout_err !== 1'b1 || ifc.res_data !== 16'hDEAD) begin
            errors++;
            $display("FAIL to_res: timeout_err=%b res_data=%h, required 1/dead", timeout_err, ifc.res_data);
        end
        ifc.res_ready = 1'b1;
        step(2);
        ifc.res_ready = 1'b0;
        checks++;
        if (timeout_err !== 1'b1 || ifc.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_sticky: timeout_err=%b res_valid=%b, required 1/0", timeout_err, ifc.res_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_weight();
        test_back_to_back();
        test_compute();
        test_stall();
        test_reset_wait();
        test_random();
`ifdef NEURAL_CMD_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
